// File: rtl/wb_arbiter.sv
// ============================================================================
//  Module      : wb_arbiter
//  Description : Round-robin arbiter that shares the general-register
//                write-back port among the ALU, load and branch/link units.
//                Valid/ready handshake on the request side, registered
//                write-back outputs, saturating conflict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int W_DATA  = 32,
    parameter int W_RADDR = 4,
    parameter int W_CNT   = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid_i,
    input  logic [W_RADDR-1:0] req0_r_i,
    input  logic [W_DATA-1:0]  req0_data_i,
    output logic               req0_ready_o,

    input  logic               req1_valid_i,
    input  logic [W_RADDR-1:0] req1_r_i,
    input  logic [W_DATA-1:0]  req1_data_i,
    output logic               req1_ready_o,

    input  logic               req2_valid_i,
    input  logic [W_RADDR-1:0] req2_r_i,
    input  logic [W_DATA-1:0]  req2_data_i,
    output logic               req2_ready_o,

    output logic               wb_o,
    output logic [W_RADDR-1:0] wb_r_o,
    output logic [W_DATA-1:0]  wb_data_o,
    output logic [1:0]         wb_src_o,

    output logic [W_CNT-1:0]   conflict_cnt_o,
    input  logic               cnt_clr_i
);

    localparam logic [W_CNT-1:0] CNT_MAX = {W_CNT{1'b1}};
    localparam logic [W_CNT-1:0] CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    // Index of the most recently granted requester; 2 after reset so that
    // requester 0 is searched first.
    logic [1:0]         last_q;

    logic [2:0]         valid;
    logic [2:0]         grant;
    logic [1:0]         grant_idx;
    logic               any_grant;
    logic               conflict;
    logic [W_RADDR-1:0] sel_r;
    logic [W_DATA-1:0]  sel_data;

    assign valid     = {req2_valid_i, req1_valid_i, req0_valid_i};
    assign any_grant = |grant;
    assign conflict  = (valid[0] & valid[1]) | (valid[0] & valid[2]) |
                       (valid[1] & valid[2]);

    // Round-robin search starting just after the last winner; readys are
    // held low while reset is asserted.
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        if (rst) begin
            case (last_q)
                2'd0: begin
                    if      (valid[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                    else if (valid[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                    else if (valid[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                end
                2'd1: begin
                    if      (valid[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                    else if (valid[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                    else if (valid[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                end
                default: begin
                    if      (valid[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                    else if (valid[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                    else if (valid[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                end
            endcase
        end
    end

    // Steer the winner's address and data toward the output register.
    always_comb begin
        sel_r    = req0_r_i;
        sel_data = req0_data_i;
        case (grant_idx)
            2'd1: begin
                sel_r    = req1_r_i;
                sel_data = req1_data_i;
            end
            2'd2: begin
                sel_r    = req2_r_i;
                sel_data = req2_data_i;
            end
            default: begin
                sel_r    = req0_r_i;
                sel_data = req0_data_i;
            end
        endcase
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign req2_ready_o = grant[2];

    // Registered write-back stage and round-robin pointer; address, data and
    // source hold their last values when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
            wb_data_o <= '0;
            wb_src_o  <= 2'd0;
            last_q    <= 2'd2;
        end else begin
            wb_o <= any_grant;
            if (any_grant) begin
                wb_r_o    <= sel_r;
                wb_data_o <= sel_data;
                wb_src_o  <= grant_idx;
                last_q    <= grant_idx;
            end
        end
    end

    // Saturating count of cycles with two or more valid requests; clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            conflict_cnt_o <= '0;
        end else if (conflict && (conflict_cnt_o != CNT_MAX)) begin
            conflict_cnt_o <= conflict_cnt_o + CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single general-register write-back port (wb, wb_r, wb_data) among three result producers:
  - requester 0: integer/logic/shift unit
  - requester 1: load unit
  - requester 2: branch/link unit
- Arbitrates with round-robin priority and uses a valid/ready handshake.
- Drives the write-back inputs of the decode stage through a registered output stage.
- Keeps a saturating conflict counter for performance monitoring.

Parameters:
- W_DATA, 32, write-back data width
- W_RADDR, 4, register address width
- W_CNT, 16, conflict counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req0_valid_i  in  1  requester 0 has a result
- req0_r_i  in  W_RADDR  requester 0 target register
- req0_data_i  in  W_DATA  requester 0 result
- req0_ready_o  out  1  requester 0 accepted this cycle
- req1_valid_i, req1_r_i, req1_data_i, req1_ready_o  as requester 0, for requester 1
- req2_valid_i, req2_r_i, req2_data_i, req2_ready_o  as requester 0, for requester 2
- wb_o  out  1  write-back enable to the register file
- wb_r_o  out  W_RADDR  write-back register address
- wb_data_o  out  W_DATA  write-back data
- wb_src_o  out  2  index of the granted requester (debug)
- conflict_cnt_o  out  W_CNT  count of cycles with ≥2 valid requests
- cnt_clr_i  in  1  synchronous clear of conflict_cnt_o

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk.
- While rst=0, all registered outputs are 0:
  - wb_o=0, wb_r_o=0, wb_data_o=0, wb_src_o=0, conflict_cnt_o=0
  - round-robin pointer last_q=2, so requester 0 has top priority after reset.
- Grant logic is combinational from the valid inputs and last_q.
  - Search order is (last_q+1) mod 3, (last_q+2) mod 3, last_q.
  - The first valid requester in that order wins.
  - Grants are one-hot or all zero.
- reqK_ready_o = grantK, combinational.
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - A requester must hold valid, r and data stable until ready.
  - Data inputs must not depend combinationally on ready.
- Output stage, one-cycle latency from grant to write-back:
  - any grant: wb_o<=1; wb_r_o<=granted r; wb_data_o<=granted data; wb_src_o<=granted index.
  - no grant: wb_o<=0; wb_r_o, wb_data_o and wb_src_o hold their previous values.
- Pointer: on any grant, last_q<=granted index. With no grant, last_q holds.
- The register file never back-pressures; one write is issued per cycle at most.
- Same target register from two requesters in the same cycle: both are written in grant order, in consecutive cycles. The later write wins in the register file. The arbiter does no merging.
- Conflict counter, applied in this priority order:
  - cnt_clr_i=1: counter <= 0. Clear overrides any increment in the same cycle.
  - otherwise, ≥2 valids: counter increments.
  - at all-ones the counter saturates and does not wrap.
- Reset mid-transfer:
  - an in-flight registered write is dropped (wb_o forced to 0);
  - requesters re-present after reset;
  - no ready is asserted while rst=0.
- Throughput:
  - a single continuously valid requester is granted every cycle;
  - three continuously valid requesters are each granted once every 3 cycles;
  - no requester waits more than 2 cycles once valid.

Test Plan:
- Reset: hold rst=0 with all valids high → all readys 0, wb_o=0, conflict_cnt_o=0. After release, the first grant goes to req0.
- Single requester: req1 valid, r=4'h5, data=32'hDEADBEEF for 1 cycle → req1_ready_o=1 the same cycle. Next cycle: wb_o=1, wb_r_o=5, wb_data_o=DEADBEEF, wb_src_o=1. The cycle after: wb_o=0.
- Round-robin: all three valid continuously for 6 cycles after reset → grant sequence 0,1,2,0,1,2. conflict_cnt_o increments 6 times if each requester stays valid (re-presents) after its grant.
- Same register: req0 (r=3, data=1) and req2 (r=3, data=2) valid with last_q=0 → req2 granted first, then req0. wb_data_o shows 2 then 1 on consecutive cycles.
- Counter: force W_CNT saturation (bench uses W_CNT=4) with 20 conflict cycles → counter stays at 4'hF. Then cnt_clr_i asserted in a conflict cycle → counter is 0 the next cycle.
- Async reset mid-stream: assert rst low between clock edges while wb_o=1 → wb_o drops to 0 immediately. After release, arbitration restarts from req0.
